// File: rtl/wfg_drive_spi_core.sv
// SPI master shift engine: serialises 8/16/24/32-bit samples onto SCLK/SDO/CS.
// Latency: CS active 1 cycle after acceptance; word occupies 3H+2NH cycles (2H+2NH with held CS).
// Backpressure: tready only in IDLE with CTRL.EN set; a word in flight blocks further samples.
module wfg_drive_spi_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ctrl_en_q_i,
    input  logic        cfg_cpol_q_i,
    input  logic        cfg_cpha_q_i,
    input  logic        cfg_lsbfirst_q_i,
    input  logic [1:0]  cfg_dff_q_i,
    input  logic        cfg_sspol_q_i,
    input  logic        cfg_ssctrl_q_i,
    input  logic [7:0]  clkcfg_div_q_i,
    input  logic [31:0] wfg_axis_tdata_i,
    input  logic        wfg_axis_tvalid_i,
    output logic        wfg_axis_tready_o,
    output logic        wfg_drive_spi_sclk_o,
    output logic        wfg_drive_spi_cs_o,
    output logic        wfg_drive_spi_sdo_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_SHIFT,
        ST_TRAIL,
        ST_GAP
    } state_t;

    state_t      state_q;
    logic [7:0]  cnt_q;        // cycles left in the current half-period, minus one
    logic [7:0]  div_q;        // divider latched at acceptance
    logic [5:0]  hp_q;         // half-period index within SHIFT, 0..2N-1
    logic [31:0] shreg_q;      // word aligned so the next bit sits at bit 31 (MSB) or bit 0 (LSB)
    logic        cpha_q;
    logic        lsb_q;
    logic        cpol_q;
    logic        sspol_q;
    logic        ssctrl_q;
    logic [1:0]  dff_q;
    logic        hold_q;       // CS kept active in IDLE after a held-CS word
    logic        rst_blk_q;    // suppresses tready in the cycle right after reset
    logic        sclk_q;
    logic        cs_q;
    logic        sdo_q;
    logic        busy_q;

    logic        accept;
    logic [4:0]  align_sh;
    logic [31:0] aligned;
    logic        first_bit;
    logic [31:0] shreg_nxt;
    logic        nxt_bit;
    logic [5:0]  hp_last;
    logic        advance;
    logic        cnt_done;

    // Handshake, word alignment and SDO advance decisions
    always_comb begin
        wfg_axis_tready_o = (state_q == ST_IDLE) && ctrl_en_q_i && !rst_blk_q;
        accept            = wfg_axis_tready_o && wfg_axis_tvalid_i;
        // MSB-first words are left-justified so bit 31 is always the next bit out
        align_sh          = {~cfg_dff_q_i, 3'b000};
        aligned           = cfg_lsbfirst_q_i ? wfg_axis_tdata_i : (wfg_axis_tdata_i << align_sh);
        first_bit         = cfg_lsbfirst_q_i ? wfg_axis_tdata_i[0] : aligned[31];
        shreg_nxt         = lsb_q ? (shreg_q >> 1) : (shreg_q << 1);
        nxt_bit           = lsb_q ? shreg_nxt[0] : shreg_nxt[31];
        hp_last           = {dff_q, 4'b1111};
        cnt_done          = (cnt_q == 8'd0);
        // hp_q is the edge number minus one: CPHA=0 advances after even edges
        // 2..2N-2, CPHA=1 after odd edges 3..2N-1
        if (cpha_q) begin
            advance = !hp_q[0] && (hp_q != 6'd0);
        end else begin
            advance = hp_q[0] && (hp_q != hp_last);
        end
    end

    // Main FSM with registered SPI outputs; dropping EN behaves like reset
    always_ff @(posedge clk) begin
        if (!rst_n || !ctrl_en_q_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 8'd0;
            div_q     <= 8'd0;
            hp_q      <= 6'd0;
            shreg_q   <= 32'd0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            cpol_q    <= 1'b0;
            sspol_q   <= 1'b0;
            ssctrl_q  <= 1'b0;
            dff_q     <= 2'd0;
            hold_q    <= 1'b0;
            rst_blk_q <= !rst_n;
            sclk_q    <= cfg_cpol_q_i;
            cs_q      <= !cfg_sspol_q_i;
            sdo_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            rst_blk_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q  <= ST_LEAD;
                        busy_q   <= 1'b1;
                        cnt_q    <= clkcfg_div_q_i;
                        div_q    <= clkcfg_div_q_i;
                        cpha_q   <= cfg_cpha_q_i;
                        lsb_q    <= cfg_lsbfirst_q_i;
                        cpol_q   <= cfg_cpol_q_i;
                        sspol_q  <= cfg_sspol_q_i;
                        ssctrl_q <= cfg_ssctrl_q_i;
                        dff_q    <= cfg_dff_q_i;
                        shreg_q  <= aligned;
                        sclk_q   <= cfg_cpol_q_i;
                        cs_q     <= cfg_sspol_q_i;
                        sdo_q    <= first_bit;
                    end else begin
                        // cpol/sspol are followed live while idle
                        sclk_q <= cfg_cpol_q_i;
                        cs_q   <= hold_q ? cfg_sspol_q_i : !cfg_sspol_q_i;
                        sdo_q  <= 1'b0;
                    end
                end
                ST_LEAD: begin
                    if (cnt_done) begin
                        state_q <= ST_SHIFT;
                        cnt_q   <= div_q;
                        hp_q    <= 6'd0;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_done) begin
                        cnt_q  <= div_q;
                        // the final edge always returns SCLK to its idle level
                        sclk_q <= (hp_q == hp_last) ? cpol_q : !sclk_q;
                        if (advance) begin
                            shreg_q <= shreg_nxt;
                            sdo_q   <= nxt_bit;
                        end
                        if (hp_q == hp_last) begin
                            state_q <= ST_TRAIL;
                        end else begin
                            hp_q <= hp_q + 6'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                ST_TRAIL: begin
                    if (cnt_done) begin
                        cnt_q  <= div_q;
                        hold_q <= ssctrl_q;
                        sdo_q  <= 1'b0;
                        if (ssctrl_q) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_GAP;
                            cs_q    <= !sspol_q;
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                ST_GAP: begin
                    if (cnt_done) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign wfg_drive_spi_sclk_o = sclk_q;
    assign wfg_drive_spi_cs_o   = cs_q;
    assign wfg_drive_spi_sdo_o  = sdo_q;
    assign busy_o               = busy_q;

endmodule
